gauss_win_ctrl: RTL and testbench

GAUSS_WIN_CTRL -- requirements
Module: gauss_win_ctrl

---
 rtl/gauss_win_ctrl.sv | 161 ++++++++++++++++
 tb/tb_gauss_win_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_win_ctrl.sv
// gauss_win_ctrl: control plane for a 3x3 Gaussian window filter.
// Tracks the column/row of every accepted pixel and drives the line-buffer
// shift enable. It flags when a complete 3x3 window is available and delays
// that flag by the datapath latency to mark valid results. It also reports
// end-of-frame, frame activity and an unexpected start-of-frame.
module gauss_win_ctrl #(
  parameter int PIC_WIDTH  = 320,
  parameter int PIC_HEIGHT = 240,
  parameter int PIPE_LAT   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  input  logic       sof_in,
  output logic       lb_shift_en,
  output logic       win_valid,
  output logic       dout_valid,
  output logic [8:0] col,
  output logic [8:0] row,
  output logic       eof_out,
  output logic       busy,
  output logic       err_sof
);

  localparam logic [8:0] COL_LAST = 9'(PIC_WIDTH - 1);
  localparam logic [8:0] ROW_LAST = 9'(PIC_HEIGHT - 1);
  localparam logic [8:0] WIN_MIN  = 9'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [8:0]    col_r;
  logic [8:0]    row_r;
  logic [8:0]    col_nxt_s;
  logic [8:0]    row_nxt_s;
  logic          win_valid_r;
  logic          win_nxt_s;
  logic          eof_r;
  logic          eof_nxt_s;
  logic          busy_r;
  logic          busy_nxt_s;
  logic          err_r;
  logic          err_nxt_s;
  logic          framing_s;
  logic          start_s;
  logic [PIPE_LAT-1:0] pipe_r;

  // A frame is in progress while filling the first two lines or running.
  assign framing_s = (state_r == ST_FILL) || (state_r == ST_RUN);

  // Any valid pixel tagged with sof starts (or restarts) a frame.
  assign start_s = valid_in && sof_in;

  // Shift enable follows each pixel that belongs to a frame; held off in reset.
  assign lb_shift_en = rst_n && valid_in && (framing_s || sof_in);

  // Next-state, counter update and registered-output decode.
  always_comb begin
    state_nxt_s = state_r;
    col_nxt_s   = col_r;
    row_nxt_s   = row_r;
    win_nxt_s   = 1'b0;
    eof_nxt_s   = 1'b0;
    err_nxt_s   = 1'b0;
    busy_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_s) begin
          state_nxt_s = ST_FILL;
          col_nxt_s   = 9'd0;
          row_nxt_s   = 9'd0;
        end else begin
          // Pixels without sof are dropped; DONE always lasts a single cycle.
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FILL, ST_RUN: begin
        if (start_s) begin
          // Mid-frame sof: restart cleanly and report it; no window for it.
          state_nxt_s = ST_FILL;
          col_nxt_s   = 9'd0;
          row_nxt_s   = 9'd0;
          err_nxt_s   = 1'b1;
        end else if (valid_in) begin
          if (col_r == COL_LAST) begin
            col_nxt_s = 9'd0;
            row_nxt_s = row_r + 9'd1;
          end else begin
            col_nxt_s = col_r + 9'd1;
            row_nxt_s = row_r;
          end
          win_nxt_s = (row_nxt_s >= WIN_MIN) && (col_nxt_s >= WIN_MIN);
          if ((col_nxt_s == COL_LAST) && (row_nxt_s == ROW_LAST)) begin
            // Last pixel of the frame: counters keep its coordinates.
            state_nxt_s = ST_DONE;
            eof_nxt_s   = 1'b1;
          end else if (row_nxt_s >= WIN_MIN) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_FILL;
          end
        end else begin
          // No pixel this cycle: everything holds.
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s == ST_FILL) || (state_nxt_s == ST_RUN);
  end

  // State, counters and status pulses, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      col_r       <= 9'd0;
      row_r       <= 9'd0;
      win_valid_r <= 1'b0;
      eof_r       <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      col_r       <= col_nxt_s;
      row_r       <= row_nxt_s;
      win_valid_r <= win_nxt_s;
      eof_r       <= eof_nxt_s;
      busy_r      <= busy_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  // Delay line matching the datapath latency; cleared so reset drops results in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_r <= '0;
    end else begin
      pipe_r[0] <= win_valid_r;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign win_valid  = win_valid_r;
  assign dout_valid = pipe_r[PIPE_LAT-1];
  assign col        = col_r;
  assign row        = row_r;
  assign eof_out    = eof_r;
  assign busy       = busy_r;
  assign err_sof    = err_r;

endmodule

// File: tb/tb_gauss_win_ctrl.sv
// Scoreboard bench for gauss_win_ctrl on an 8x4 picture with a 2-cycle datapath.
module tb_gauss_win_ctrl;

  localparam int W = 8;
  localparam int H = 4;
  localparam int L = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic       sof_in;
  logic       lb_shift_en;
  logic       win_valid;
  logic       dout_valid;
  logic [8:0] col;
  logic [8:0] row;
  logic       eof_out;
  logic       busy;
  logic       err_sof;

  gauss_win_ctrl #(.PIC_WIDTH(W), .PIC_HEIGHT(H), .PIPE_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof_in(sof_in),
    .lb_shift_en(lb_shift_en), .win_valid(win_valid), .dout_valid(dout_valid),
    .col(col), .row(row), .eof_out(eof_out), .busy(busy), .err_sof(err_sof)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; int c; int r; } win_ev_t;
  win_ev_t win_q[$];
  int      dout_q[$];
  int      eof_q[$];
  int      err_q[$];

  int win_seen = 0, dout_seen = 0, eof_seen = 0;
  int base_w, base_d, base_e;

  // Expected frame position, tracked by the stimulus side.
  bit m_active = 1'b0;
  int m_col = 0;
  int m_row = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pop expected events when due, flag any unexpected pulse.
  always @(negedge clk) begin
    win_ev_t e;
    if (win_valid === 1'b1) win_seen++;
    if (dout_valid === 1'b1) dout_seen++;
    if (eof_out === 1'b1) eof_seen++;
    if (win_q.size() > 0 && win_q[0].cyc == cyc) begin
      e = win_q.pop_front();
      chk("win_valid", win_valid, 1);
      chk("win_col", col, e.c);
      chk("win_row", row, e.r);
    end else if (win_valid !== 1'b0) begin
      chk("win_valid_unexpected", win_valid, 0);
    end
    if (dout_q.size() > 0 && dout_q[0] == cyc) begin
      void'(dout_q.pop_front());
      chk("dout_valid", dout_valid, 1);
    end else if (dout_valid !== 1'b0) begin
      chk("dout_valid_unexpected", dout_valid, 0);
    end
    if (eof_q.size() > 0 && eof_q[0] == cyc) begin
      void'(eof_q.pop_front());
      chk("eof_out", eof_out, 1);
    end else if (eof_out !== 1'b0) begin
      chk("eof_out_unexpected", eof_out, 0);
    end
    if (err_q.size() > 0 && err_q[0] == cyc) begin
      void'(err_q.pop_front());
      chk("err_sof", err_sof, 1);
    end else if (err_sof !== 1'b0) begin
      chk("err_sof_unexpected", err_sof, 0);
    end
  end

  // One input cycle: push expected events, check shift enable and counters.
  task automatic pix(input bit v, input bit s);
    bit exp_shift, ew, ee, er;
    ew = 1'b0; ee = 1'b0; er = 1'b0;
    @(negedge clk);
    valid_in = v;
    sof_in   = s;
    exp_shift = v && (m_active || s);
    if (v && s) begin
      er = m_active;
      m_col = 0; m_row = 0; m_active = 1'b1;
    end else if (v && m_active) begin
      if (m_col == W - 1) begin m_col = 0; m_row++; end
      else m_col++;
      ew = (m_row >= 2) && (m_col >= 2);
      if (m_col == W - 1 && m_row == H - 1) begin ee = 1'b1; m_active = 1'b0; end
    end
    if (ew) begin
      win_q.push_back('{cyc + 1, m_col, m_row});
      dout_q.push_back(cyc + 1 + L);
    end
    if (ee) eof_q.push_back(cyc + 1);
    if (er) err_q.push_back(cyc + 1);
    #1 chk("lb_shift_en", lb_shift_en, exp_shift);
    @(posedge clk);
    #1;
    chk("col", col, m_col);
    chk("row", row, m_row);
    chk("busy", busy, m_active);
  endtask

  task automatic idle(input int n);
    repeat (n) pix(1'b0, 1'b0);
  endtask

  task automatic frame(input bit gaps);
    for (int k = 0; k < W * H; k++) begin
      pix(1'b1, k == 0);
      if (gaps) pix(1'b0, 1'b0);
    end
  endtask

  // One reset cycle with a pixel presented; everything in flight is discarded.
  task automatic do_reset(input bit v);
    @(negedge clk);
    rst_n = 1'b0; valid_in = v; sof_in = 1'b0;
    #1;
    win_q.delete(); dout_q.delete(); eof_q.delete(); err_q.delete();
    m_active = 1'b0; m_col = 0; m_row = 0;
    chk("lb_shift_en_in_reset", lb_shift_en, 0);
    @(posedge clk);
    #1;
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_eof_out", eof_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_sof", err_sof, 0);
    @(negedge clk);
    rst_n = 1'b1; valid_in = 1'b0;
  endtask

  task automatic sec_begin();
    base_w = win_seen; base_d = dout_seen; base_e = eof_seen;
  endtask

  task automatic sec_end(input string name, input int ew, input int ed, input int ee);
    chk({name, "_win_pulses"}, win_seen - base_w, ew);
    chk({name, "_dout_pulses"}, dout_seen - base_d, ed);
    chk({name, "_eof_pulses"}, eof_seen - base_e, ee);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b1; sof_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("init_lb_shift_en", lb_shift_en, 0);
    chk("init_col", col, 0);
    chk("init_row", row, 0);
    chk("init_win_valid", win_valid, 0);
    chk("init_dout_valid", dout_valid, 0);
    chk("init_eof_out", eof_out, 0);
    chk("init_busy", busy, 0);
    chk("init_err_sof", err_sof, 0);
    @(negedge clk);
    rst_n = 1'b1; valid_in = 1'b0; sof_in = 1'b0;

    // Pixels without sof after reset are ignored.
    sec_begin(); repeat (5) pix(1'b1, 1'b0); idle(2); sec_end("idle_no_sof", 0, 0, 0);

    // Contiguous frame.
    sec_begin(); frame(1'b0); idle(3); sec_end("contig", 12, 12, 1);

    // Same frame with a gap after every pixel.
    sec_begin(); frame(1'b1); idle(3); sec_end("gapped", 12, 12, 1);

    // sof at pixel 20 (row 2, col 3): one window before restart, then a full frame.
    sec_begin();
    for (int k = 0; k < 19; k++) pix(1'b1, k == 0);
    pix(1'b1, 1'b1);
    for (int k = 0; k < 31; k++) pix(1'b1, 1'b0);
    idle(3);
    sec_end("midframe_sof", 13, 13, 1);

    // Reset at pixel 18, then a normal frame.
    sec_begin();
    for (int k = 0; k < 17; k++) pix(1'b1, k == 0);
    do_reset(1'b1);
    frame(1'b0); idle(3);
    sec_end("reset_px18", 12, 12, 1);

    // Reset while results are in flight: windows seen, results dropped.
    sec_begin();
    for (int k = 0; k < 20; k++) pix(1'b1, k == 0);
    do_reset(1'b1);
    idle(3);
    sec_end("reset_in_flight", 2, 0, 0);

    // Back-to-back frames, second sof lands in DONE.
    sec_begin(); frame(1'b0); frame(1'b0); idle(3); sec_end("back2back", 24, 24, 2);

    chk("win_q_drained", win_q.size(), 0);
    chk("dout_q_drained", dout_q.size(), 0);
    chk("eof_q_drained", eof_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
